// File: rtl/cla_serial_pkg.sv
// Shared definitions for the serial carry-lookahead adder: state encoding,
// slice width and the slice-index width helper.
package cla_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SLICE_W = 2;

    // Index width for WIDTH/2 slices, never narrower than one bit.
    function automatic int idx_width(input int width);
        int n;
        n = $clog2(width / 2);
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/cla2_slice.sv
// Combinational 2-bit propagate/generate carry-lookahead slice.
// Latency: zero (pure combinational); no backpressure.
module cla2_slice (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       cin,
    output logic [1:0] sum,
    output logic       cout
);

    logic [1:0] p;
    logic [1:0] g;
    logic       c1;

    assign p    = a ^ b;
    assign g    = a & b;
    assign c1   = g[0] | (p[0] & cin);
    assign cout = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign sum  = {p[1] ^ c1, p[0] ^ cin};

endmodule

// File: rtl/cla_serial_adder.sv
// Iterative WIDTH-bit adder, 2 bits per cycle through one CLA slice; done WIDTH/2+1 cycles after start.
// start is ignored while busy. Optional signed overflow output via CLA_SERIAL_ADDER_OVF_EN.
module cla_serial_adder
    import cla_serial_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int IW = idx_width(WIDTH);
    localparam int NSL = WIDTH / SLICE_W;
    localparam logic [IW-1:0] LAST_IDX = IW'(NSL - 1);

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_bad_width
            $error("cla_serial_adder: WIDTH must be even and >= 2");
        end
    endgenerate

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [IW-1:0]    idx;
    logic [IW:0]      bit_pos;
    logic [1:0]       sl_a;
    logic [1:0]       sl_b;
    logic [1:0]       sl_sum;
    logic             sl_cout;
    logic             accept;
    logic             last;

    assign accept  = start && (state == IDLE || state == DONE);
    assign last    = (state == RUN) && (idx == LAST_IDX);
    assign bit_pos = {idx, 1'b0};
    assign sl_a    = a_sh[bit_pos +: SLICE_W];
    assign sl_b    = b_sh[bit_pos +: SLICE_W];

    cla2_slice u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry),
        .sum  (sl_sum),
        .cout (sl_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Sum is cleared at capture so bits above the current slice read zero mid-add.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            carry <= 1'b0;
            idx   <= '0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            sum   <= '0;
            carry <= cin;
            idx   <= '0;
        end else if (state == RUN) begin
            sum[bit_pos +: SLICE_W] <= sl_sum;
            carry                   <= sl_cout;
            idx                     <= idx + 1'b1;
            if (last) begin
                cout <= sl_cout;
            end
        end
    end

`ifdef CLA_SERIAL_ADDER_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (last) begin
            ovf_q <= (a_sh[WIDTH-1] == b_sh[WIDTH-1]) && (sl_sum[1] != a_sh[WIDTH-1]);
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule
